// File: rtl/pe_feeder.sv
// pe_feeder: streams filter words, then row-tagged IFM words, from two
// 1-cycle-latency scratch memories into one PE's write ports.
//
// Handshake (both PE write ports): a word moves on a rising edge where
// w_en_x=1 and ready_x=1. Once w_en_x is raised it stays high, and
// data_in_x stays unchanged, until that edge happens. ready_x may change
// freely and never has a combinational effect on w_en_x or data_in_x.
//
// Each stream is a 2-entry prefetch FIFO with fall-through: a word read
// last cycle is offered straight from the memory data bus when the FIFO is
// empty. If it is not taken, it is captured in the FIFO. This keeps the
// start-to-first-word latency at two cycles and the rate at one word per
// cycle. The first IFM read is issued in the same cycle as the final filter
// handshake, so the IFM stream follows the filter stream with no gap.
module pe_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int PAR_WRITE  = 1,
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [LEN_WIDTH-1:0]              fil_len,
    input  logic [LEN_WIDTH-1:0]              row_len,
    input  logic [LEN_WIDTH-1:0]              ifm_rows,
    output logic [ADDR_WIDTH-1:0]             fil_addr,
    output logic                              fil_ren,
    input  logic [DATA_WIDTH*PAR_WRITE-1:0]   fil_rdata,
    output logic [ADDR_WIDTH-1:0]             ifm_addr,
    output logic                              ifm_ren,
    input  logic [DATA_WIDTH*PAR_WRITE-1:0]   ifm_rdata,
    output logic                              w_en_fil,
    output logic [DATA_WIDTH*PAR_WRITE-1:0]   data_in_fil,
    input  logic                              ready_fil,
    output logic                              w_en_ifm,
    output logic [DATA_WIDTH*PAR_WRITE+1:0]   data_in_ifm,
    input  logic                              ready_ifm,
    output logic                              busy,
    output logic                              done,
    output logic [1:0]                        dbg_state
);

    localparam int WW = DATA_WIDTH * PAR_WRITE;
    localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = LEN_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FIL  = 2'd1,
        S_IFM  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Lengths captured when a transfer is accepted
    logic [LEN_WIDTH-1:0]  r_fil_len;
    logic [LEN_WIDTH-1:0]  r_row_len;
    logic [LEN_WIDTH-1:0]  r_ifm_rows;

    // Filter issue/send bookkeeping
    logic [ADDR_WIDTH-1:0] r_fil_addr;
    logic [LEN_WIDTH-1:0]  r_fil_issued;
    logic [LEN_WIDTH-1:0]  r_fil_sent;

    // IFM issue bookkeeping (row-major walk) and send bookkeeping
    logic [ADDR_WIDTH-1:0] r_ifm_addr;
    logic [LEN_WIDTH-1:0]  r_ifm_col;
    logic [LEN_WIDTH-1:0]  r_ifm_row;
    logic [LEN_WIDTH-1:0]  r_ifm_sent_row;
    logic [1:0]            r_ifm_flags;   // {sor, eor} of the read in flight

    logic                  w_accept;
    logic                  w_fil_issue;
    logic                  w_fil_room;
    logic                  w_fil_valid;
    logic                  w_fil_fire;
    logic [WW-1:0]         w_fil_data;
    logic                  w_fil_last;
    logic                  w_ifm_nonempty;
    logic                  w_ifm_phase;
    logic                  w_ifm_issue;
    logic                  w_ifm_room;
    logic                  w_ifm_valid;
    logic                  w_ifm_fire;
    logic [WW+1:0]         w_ifm_data;
    logic [WW+1:0]         w_ifm_rd;
    logic                  w_ifm_last;
    logic                  w_sor;
    logic                  w_col_last;

    assign w_accept       = (r_state == S_IDLE) && start;
    assign w_ifm_nonempty = (r_row_len != '0) && (r_ifm_rows != '0);

    assign w_fil_issue = (r_state == S_FIL) && (r_fil_issued != r_fil_len) && w_fil_room;
    assign w_fil_last  = (r_state == S_FIL) && w_fil_fire && (r_fil_sent == r_fil_len - LEN_ONE);

    // IFM reads may start on the final filter handshake, never earlier
    assign w_ifm_phase = (r_state == S_IFM) || (w_fil_last && w_ifm_nonempty);
    assign w_ifm_issue = w_ifm_phase && (r_ifm_row != r_ifm_rows) && w_ifm_room;

    assign w_sor      = (r_ifm_col == '0);
    assign w_col_last = (r_ifm_col == r_row_len - LEN_ONE);
    assign w_ifm_rd   = {r_ifm_flags, ifm_rdata};

    // Last IFM word = end-of-row word of the final row
    assign w_ifm_last = (r_state == S_IFM) && w_ifm_fire && w_ifm_data[WW] &&
                        (r_ifm_sent_row == r_ifm_rows - LEN_ONE);

    pe_feeder_stream #(.W(WW)) u_fil_stream (
        .clk     (clk),
        .rst     (rst),
        .i_issue (w_fil_issue),
        .i_rdata (fil_rdata),
        .i_ready (ready_fil),
        .o_valid (w_fil_valid),
        .o_data  (w_fil_data),
        .o_room  (w_fil_room),
        .o_fire  (w_fil_fire)
    );

    pe_feeder_stream #(.W(WW + 2)) u_ifm_stream (
        .clk     (clk),
        .rst     (rst),
        .i_issue (w_ifm_issue),
        .i_rdata (w_ifm_rd),
        .i_ready (ready_ifm),
        .o_valid (w_ifm_valid),
        .o_data  (w_ifm_data),
        .o_room  (w_ifm_room),
        .o_fire  (w_ifm_fire)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: filter phase, then IFM phase, then a one-cycle finish
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (fil_len != '0) begin
                        w_state_nxt = S_FIL;
                    end else if ((row_len != '0) && (ifm_rows != '0)) begin
                        w_state_nxt = S_IFM;
                    end else begin
                        w_state_nxt = S_FIN;
                    end
                end
            end
            S_FIL: begin
                if (w_fil_last) begin
                    w_state_nxt = w_ifm_nonempty ? S_IFM : S_FIN;
                end
            end
            S_IFM: begin
                if (w_ifm_last) begin
                    w_state_nxt = S_FIN;
                end
            end
            S_FIN: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Length capture and address/row/column counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fil_len      <= '0;
            r_row_len      <= '0;
            r_ifm_rows     <= '0;
            r_fil_addr     <= '0;
            r_fil_issued   <= '0;
            r_fil_sent     <= '0;
            r_ifm_addr     <= '0;
            r_ifm_col      <= '0;
            r_ifm_row      <= '0;
            r_ifm_sent_row <= '0;
            r_ifm_flags    <= '0;
        end else if (w_accept) begin
            r_fil_len      <= fil_len;
            r_row_len      <= row_len;
            r_ifm_rows     <= ifm_rows;
            r_fil_addr     <= '0;
            r_fil_issued   <= '0;
            r_fil_sent     <= '0;
            r_ifm_addr     <= '0;
            r_ifm_col      <= '0;
            r_ifm_row      <= '0;
            r_ifm_sent_row <= '0;
            r_ifm_flags    <= '0;
        end else begin
            if (w_fil_issue) begin
                r_fil_addr   <= r_fil_addr + ADDR_ONE;
                r_fil_issued <= r_fil_issued + LEN_ONE;
            end
            if (w_fil_fire && (r_state == S_FIL)) begin
                r_fil_sent <= r_fil_sent + LEN_ONE;
            end
            if (w_ifm_issue) begin
                r_ifm_addr  <= r_ifm_addr + ADDR_ONE;
                r_ifm_flags <= {w_sor, w_col_last};
                if (w_col_last) begin
                    r_ifm_col <= '0;
                    r_ifm_row <= r_ifm_row + LEN_ONE;
                end else begin
                    r_ifm_col <= r_ifm_col + LEN_ONE;
                end
            end
            if (w_ifm_fire && w_ifm_data[WW]) begin
                r_ifm_sent_row <= r_ifm_sent_row + LEN_ONE;
            end
        end
    end

    assign fil_addr    = r_fil_addr;
    assign fil_ren     = w_fil_issue;
    assign ifm_addr    = r_ifm_addr;
    assign ifm_ren     = w_ifm_issue;
    assign w_en_fil    = w_fil_valid;
    assign data_in_fil = w_fil_data;
    assign w_en_ifm    = w_ifm_valid;
    assign data_in_ifm = w_ifm_data;
    assign busy        = (r_state == S_FIL) || (r_state == S_IFM);
    assign done        = (r_state == S_FIN);
    assign dbg_state   = r_state;

endmodule

// One prefetch stream: tracks the read in flight, holds up to two words,
// and presents the oldest word (or the in-flight word when empty).
// Occupancy plus in-flight reads never exceeds two.
module pe_feeder_stream #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_issue,
    input  logic [W-1:0] i_rdata,
    input  logic         i_ready,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    output logic         o_room,
    output logic         o_fire
);

    logic         r_inflight;
    logic [W-1:0] r_mem [2];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;

    logic         w_head_valid;
    logic         w_push;
    logic         w_pop;

    assign w_head_valid = (r_count != 2'd0);
    assign o_valid      = w_head_valid || r_inflight;
    assign o_fire       = o_valid && i_ready;
    assign w_pop        = o_fire && w_head_valid;
    // The in-flight word is stored unless it was taken straight off the bus
    assign w_push       = r_inflight && !(o_fire && !w_head_valid);
    assign o_room       = ({1'b0, r_count} + {2'b00, r_inflight}) < 3'd2;

    // Output word: FIFO head first, else the word arriving from memory
    always_comb begin
        o_data = '0;
        if (w_head_valid) begin
            o_data = r_mem[r_rd_ptr];
        end else if (r_inflight) begin
            o_data = i_rdata;
        end
    end

    // In-flight flag, pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight <= 1'b0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_count    <= 2'd0;
        end else begin
            r_inflight <= i_issue;
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    // Storage; contents are only meaningful where the count says so
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_rdata;
        end
    end

endmodule

// File: tb/tb_pe_feeder.sv
// Bench for pe_feeder: memory models, a driver, and a monitor that pops
// expected words from per-stream queues on every PE-side transfer.
module tb_pe_feeder;

    localparam int WW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [7:0]      fil_len;
    logic [7:0]      row_len;
    logic [7:0]      ifm_rows;
    logic [7:0]      fil_addr;
    logic            fil_ren;
    logic [WW-1:0]   fil_rdata;
    logic [7:0]      ifm_addr;
    logic            ifm_ren;
    logic [WW-1:0]   ifm_rdata;
    logic            w_en_fil;
    logic [WW-1:0]   data_in_fil;
    logic            ready_fil;
    logic            w_en_ifm;
    logic [WW+1:0]   data_in_ifm;
    logic            ready_ifm;
    logic            busy;
    logic            done;
    logic [1:0]      dbg_state;

    pe_feeder #(
        .DATA_WIDTH(8), .PAR_WRITE(1), .ADDR_WIDTH(8), .LEN_WIDTH(8)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .fil_len(fil_len), .row_len(row_len), .ifm_rows(ifm_rows),
        .fil_addr(fil_addr), .fil_ren(fil_ren), .fil_rdata(fil_rdata),
        .ifm_addr(ifm_addr), .ifm_ren(ifm_ren), .ifm_rdata(ifm_rdata),
        .w_en_fil(w_en_fil), .data_in_fil(data_in_fil), .ready_fil(ready_fil),
        .w_en_ifm(w_en_ifm), .data_in_ifm(data_in_ifm), .ready_ifm(ready_ifm),
        .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Source memories with one cycle of read latency
    logic [WW-1:0] fil_mem [256];
    logic [WW-1:0] ifm_mem [256];
    always @(posedge clk) begin
        if (fil_ren) fil_rdata <= fil_mem[fil_addr];
        if (ifm_ren) ifm_rdata <= ifm_mem[ifm_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard state
    logic [WW-1:0] fil_exp_q [$];
    logic [WW+1:0] ifm_exp_q [$];
    int errors = 0;
    int checks = 0;
    int fil_rd_cnt, ifm_rd_cnt, fil_xfer, ifm_xfer;
    int done_cnt, done_cyc, first_fil_cyc, start_cyc, max_out, overlap_err, cur_fil_len;
    logic fil_stall = 1'b0;
    logic ifm_stall = 1'b0;
    logic [WW-1:0] fil_hold;
    logic [WW+1:0] ifm_hold;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: sampled on the falling edge, between active edges
    initial begin
        logic [WW-1:0] ef;
        logic [WW+1:0] ei;
        int out;
        forever begin
            @(negedge clk);
            if (rst) begin
                fil_stall = 1'b0;
                ifm_stall = 1'b0;
            end else begin
                if (fil_stall) begin
                    check("fil_hold_en", {31'd0, w_en_fil}, 1);
                    check("fil_hold_data", {24'd0, data_in_fil}, {24'd0, fil_hold});
                end
                if (ifm_stall) begin
                    check("ifm_hold_en", {31'd0, w_en_ifm}, 1);
                    check("ifm_hold_data", {22'd0, data_in_ifm}, {22'd0, ifm_hold});
                end
                fil_stall = w_en_fil && !ready_fil;
                fil_hold  = data_in_fil;
                ifm_stall = w_en_ifm && !ready_ifm;
                ifm_hold  = data_in_ifm;
                if (w_en_fil && first_fil_cyc < 0) first_fil_cyc = cyc;
                if (w_en_fil && ready_fil) begin
                    if (fil_exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL fil_unexpected: got %0h expected no word", data_in_fil);
                    end else begin
                        ef = fil_exp_q.pop_front();
                        check("fil_word", {24'd0, data_in_fil}, {24'd0, ef});
                    end
                    fil_xfer++;
                end
                if (w_en_ifm && ready_ifm) begin
                    if (ifm_exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL ifm_unexpected: got %0h expected no word", data_in_ifm);
                    end else begin
                        ei = ifm_exp_q.pop_front();
                        check("ifm_word", {22'd0, data_in_ifm}, {22'd0, ei});
                    end
                    ifm_xfer++;
                end
                if (fil_ren) begin
                    check("fil_addr", {24'd0, fil_addr}, fil_rd_cnt);
                    fil_rd_cnt++;
                end
                if (ifm_ren) begin
                    check("ifm_addr", {24'd0, ifm_addr}, ifm_rd_cnt);
                    if (fil_xfer < cur_fil_len) overlap_err++;
                    ifm_rd_cnt++;
                end
                out = fil_rd_cnt - fil_xfer;
                if (out > max_out) max_out = out;
                out = ifm_rd_cnt - ifm_xfer;
                if (out > max_out) max_out = out;
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
            end
        end
    end

    task automatic clear_stats(input int fl);
        cur_fil_len   = fl;
        fil_rd_cnt    = 0;
        ifm_rd_cnt    = 0;
        fil_xfer      = 0;
        ifm_xfer      = 0;
        done_cnt      = 0;
        done_cyc      = -1;
        first_fil_cyc = -1;
        max_out       = 0;
        overlap_err   = 0;
    endtask

    task automatic push_expected(input int fl, input int rl, input int nr);
        logic [WW+1:0] e;
        logic sor, eor;
        for (int i = 0; i < fl; i++) fil_exp_q.push_back(fil_mem[i]);
        for (int r = 0; r < nr; r++) begin
            for (int c = 0; c < rl; c++) begin
                sor = (c == 0);
                eor = (c == rl - 1);
                e = {sor, eor, ifm_mem[r * rl + c]};
                ifm_exp_q.push_back(e);
            end
        end
    endtask

    task automatic set_ready(input int fmode, input int imode, input int k);
        ready_fil = (fmode == 2) ? (k >= 10) : 1'b1;
        ready_ifm = (imode == 1) ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_fil_addr"}, {24'd0, fil_addr}, 0);
        check({tag, "_fil_ren"}, {31'd0, fil_ren}, 0);
        check({tag, "_ifm_addr"}, {24'd0, ifm_addr}, 0);
        check({tag, "_ifm_ren"}, {31'd0, ifm_ren}, 0);
        check({tag, "_w_en_fil"}, {31'd0, w_en_fil}, 0);
        check({tag, "_data_fil"}, {24'd0, data_in_fil}, 0);
        check({tag, "_w_en_ifm"}, {31'd0, w_en_ifm}, 0);
        check({tag, "_data_ifm"}, {22'd0, data_in_ifm}, 0);
        check({tag, "_busy"}, {31'd0, busy}, 0);
        check({tag, "_done"}, {31'd0, done}, 0);
        check({tag, "_state"}, {30'd0, dbg_state}, 0);
    endtask

    // One complete transfer; exp_lat < 0 skips the latency checks
    task automatic run(input int fl, input int rl, input int nr, input int fmode,
                       input int imode, input int exp_lat, input bit second_start);
        bit seen;
        clear_stats(fl);
        push_expected(fl, rl, nr);
        @(posedge clk); #1;
        fil_len  = fl[7:0];
        row_len  = rl[7:0];
        ifm_rows = nr[7:0];
        start    = 1'b1;
        start_cyc = cyc;
        set_ready(fmode, imode, 0);
        seen = 1'b0;
        for (int k = 1; k <= 300 && !seen; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (second_start && k == 8) begin
                start    = 1'b1;
                fil_len  = 8'd5;
                row_len  = 8'd4;
                ifm_rows = 8'd4;
            end
            set_ready(fmode, imode, k);
            if (k == 1) check("busy_after_start", {31'd0, busy}, 1);
            if (fmode == 2 && k == 10) begin
                check("fil_reads_during_stall", fil_rd_cnt, 2);
                check("ifm_reads_during_stall", ifm_rd_cnt, 0);
            end
            if (done_cnt > 0) seen = 1'b1;
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL done_timeout: got no done expected done within 300 cycles");
        end
        repeat (4) @(posedge clk);
        #1;
        check("done_pulses", done_cnt, 1);
        check("fil_words_left", fil_exp_q.size(), 0);
        check("ifm_words_left", ifm_exp_q.size(), 0);
        check("fil_read_count", fil_rd_cnt, fl);
        check("ifm_read_count", ifm_rd_cnt, rl * nr);
        check("outstanding_le_2", {31'd0, (max_out <= 2)}, 1);
        check("ifm_before_fil_end", overlap_err, 0);
        check("busy_after_done", {31'd0, busy}, 0);
        if (fl == 0) check("no_w_en_fil", first_fil_cyc, -1);
        if (exp_lat >= 0) begin
            check("done_latency", done_cyc - start_cyc, exp_lat);
            if (fl > 0) check("first_fil_latency", first_fil_cyc - start_cyc, 2);
        end
        fil_exp_q.delete();
        ifm_exp_q.delete();
    endtask

    // Driver
    initial begin
        rst = 1'b1;
        start = 1'b0;
        fil_len = '0;
        row_len = '0;
        ifm_rows = '0;
        ready_fil = 1'b1;
        ready_ifm = 1'b1;
        for (int i = 0; i < 256; i++) begin
            fil_mem[i] = i[7:0];
            ifm_mem[i] = i[7:0];
        end
        clear_stats(0);
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("por");
        rst = 1'b0;

        // Reset mid-filter stream
        clear_stats(8);
        push_expected(8, 2, 2);
        @(posedge clk); #1;
        fil_len = 8'd8; row_len = 8'd2; ifm_rows = 8'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mid_fil_busy", {31'd0, busy}, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check_outputs_zero("rst");
        @(posedge clk); #1;
        rst = 1'b0;
        fil_exp_q.delete();
        ifm_exp_q.delete();
        repeat (6) @(posedge clk);
        #1;
        check("no_done_after_abort", done_cnt, 0);
        check("idle_after_abort", {30'd0, dbg_state}, 0);

        // Full rate: 4 filter words, 2 rows of 3
        run(4, 3, 2, 0, 0, 12, 1'b0);

        for (int i = 0; i < 256; i++) ifm_mem[i] = 8'(i * 7 + 3);

        // IFM backpressure 1,0,0,1
        run(2, 3, 2, 0, 1, -1, 1'b0);
        // Degenerate sizes
        run(0, 2, 2, 0, 0, 6, 1'b0);
        run(2, 1, 3, 0, 0, 7, 1'b0);
        run(3, 2, 0, 0, 0, 5, 1'b0);
        // Second start during IFM is ignored
        run(2, 3, 3, 0, 0, 13, 1'b1);
        // Filter stalled for the first 10 cycles
        run(4, 2, 2, 2, 0, 18, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
